// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg
//   Shared definitions for the writeback stage: datapath width, result-select
//   encodings, load funct3 codes, the long-latency buffer entry layout and the
//   load-data extraction helper.
package wb_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Result select carried down from decode. The reserved code behaves as ALU.
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_PC4  = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_e;

  // Load width/sign encodings (funct3 of the load instruction).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One buffered long-latency result: destination plus value (37 bits).
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } lu_entry_t;

  // Pick the addressed byte/half out of the aligned memory word and extend it.
  // Halves are selected by addr[1] only; addr[0] is ignored for them.
  // Unknown funct3 codes pass the full word through.
  function automatic logic [XLEN-1:0] load_extract(
    input logic [2:0]      funct3,
    input logic [1:0]      addr,
    input logic [XLEN-1:0] word
  );
    logic [7:0]      byte_val;
    logic [15:0]     half_val;
    logic [XLEN-1:0] result;
    case (addr)
      2'd0:    byte_val = word[7:0];
      2'd1:    byte_val = word[15:8];
      2'd2:    byte_val = word[23:16];
      default: byte_val = word[31:24];
    endcase
    half_val = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_val[7]}}, byte_val};
      F3_LH:   result = {{16{half_val[15]}}, half_val};
      F3_LW:   result = word;
      F3_LBU:  result = {24'd0, byte_val};
      F3_LHU:  result = {16'd0, half_val};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo
//   Small synchronous FIFO holding long-latency results until the register
//   file write port is free. DEPTH must be a power of two, >= 2.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   push       write push_data (ignored when full)
//   push_data  entry to store
//   pop        discard head (ignored when empty)
//   pop_data   current head entry (valid when !empty)
//   full       no free slot
//   empty      no stored entry
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = storage[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage
//   Writeback stage and sole driver of the register file write port. Registers
//   the MEM result (with load extraction), buffers long-latency unit results,
//   and arbitrates the port: pipeline first, buffer when the port is unclaimed.
//   A starvation counter requests a pipeline bubble so the buffer always drains.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   mem_valid/write_reg/rd   MEM-stage instruction and its destination
//   mem_wb_sel, mem_funct3   result select and load width/sign
//   mem_alu_result           ALU result, also load address
//   mem_load_data            raw aligned memory word
//   mem_pc_plus4             link value
//   lu_valid/rd/data         offered long-latency result
//   lu_ready                 buffer can accept
//   stall_req                hold MEM and inject a bubble into WB
//   write_reg, target_reg,   register file write enable, address, data
//   write_rd_data            (address/data are zero whenever enable is low)
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_write_reg,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wb_sel,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic            stall_req,
  output logic            write_reg,
  output logic [4:0]      target_reg,
  output logic [XLEN-1:0] write_rd_data
);

  localparam int              CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   STARVE_MAX = CW'(STARVE_LIMIT);

  logic            wb_valid;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_result;
  logic [XLEN-1:0] mem_result;

  logic            claimed;
  logic            fifo_full;
  logic            fifo_empty;
  logic            lu_push;
  logic            lu_pop;
  lu_entry_t       lu_in;
  lu_entry_t       lu_head;
  logic [CW-1:0]   starve_cnt;

  // Choose the value the MEM instruction will write back.
  always_comb begin
    mem_result = mem_alu_result;
    case (wb_sel_e'(mem_wb_sel))
      WB_SEL_LOAD: mem_result = load_extract(mem_funct3, mem_alu_result[1:0], mem_load_data);
      WB_SEL_PC4:  mem_result = mem_pc_plus4;
      default:     mem_result = mem_alu_result;
    endcase
  end

  // WB pipeline register; a stall request replaces the incoming entry with a
  // bubble so the buffer gets the port for that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_result <= '0;
    end else if (stall_req) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_result <= '0;
    end else begin
      wb_valid  <= mem_valid;
      wb_we     <= mem_write_reg;
      wb_rd     <= mem_rd;
      wb_result <= mem_result;
    end
  end

  assign claimed = wb_valid && wb_we && (wb_rd != 5'd0);

  // lu_ready depends only on registered occupancy, and is held low in reset.
  assign lu_ready   = rst && !fifo_full;
  assign lu_push    = lu_valid && lu_ready;
  assign lu_pop     = !fifo_empty && !claimed;
  assign lu_in.rd   = lu_rd;
  assign lu_in.data = lu_data;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(lu_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (lu_push),
    .push_data (lu_in),
    .pop       (lu_pop),
    .pop_data  (lu_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Counts cycles the buffer has waited without draining; saturates so the
  // stall request stays up until the forced bubble lets the head pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || lu_pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign stall_req = (starve_cnt == STARVE_MAX);

  // Port arbitration. A popped entry for x0 is dropped without a write, and
  // address/data stay zero when no write is issued.
  always_comb begin
    write_reg     = 1'b0;
    target_reg    = '0;
    write_rd_data = '0;
    if (claimed) begin
      write_reg     = 1'b1;
      target_reg    = wb_rd;
      write_rd_data = wb_result;
    end else if (lu_pop && (lu_head.rd != 5'd0)) begin
      write_reg     = 1'b1;
      target_reg    = lu_head.rd;
      write_rd_data = lu_head.data;
    end
  end

endmodule
